// File: rtl/io_bus_pkg.sv
// Shared definitions for the two-master I/O bus arbiter: FSM states, the
// default I/O window and the peripheral register map.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic [31:0] IO_ADDR_BASE = 32'hF000_0000;
    localparam logic [31:0] IO_ADDR_MASK = 32'hFFFF_F000;

    localparam logic [31:0] TCNT_ADDR = 32'hF000_0020;
    localparam logic [31:0] TLIM_ADDR = 32'hF000_0024;
    localparam logic [31:0] TCTL_ADDR = 32'hF000_0120;

    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/io_rr_pick.sv
// Combinational 2-way round-robin picker: ptr names the favoured master when
// both request; a lone requester always wins.
module io_rr_pick
    import io_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       valid,
    output logic       winner
);

    assign valid  = |req;
    assign winner = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter onto a single-beat I/O bus with window decode.
// Optional ownership lock is built only when IO_ARB_LOCK_EN is defined.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = IO_ADDR_BASE,
    parameter logic [31:0] ADDR_MASK = IO_ADDR_MASK,
    parameter int          LOCK_MAX  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        wren0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        lock0,
    output logic        gnt0,
    output logic [31:0] rdata0,
    output logic        rvalid0,
    output logic        err0,
    input  logic        req1,
    input  logic        wren1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        lock1,
    output logic        gnt1,
    output logic [31:0] rdata1,
    output logic        rvalid1,
    output logic        err1,
    output logic [31:0] abus,
    output logic [31:0] dbus_in,
    output logic        wren,
    input  logic [31:0] dbus_out
);

    arb_state_e  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic [31:0] abus_q, abus_d, dbus_in_q, dbus_in_d;
    logic        wren_q, wren_d;
    logic        beat_rd_q, beat_rd_d, beat_err_q, beat_err_d;
    logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [1:0]  pick_req;
    logic        pick_vld, pick_win, stay;
    logic        own_nxt, sel_nxt, win_nxt, wr_nxt;
    logic [31:0] addr_nxt, wdata_nxt;

    // The owner's request is consumed by its own beat, so it cannot re-win at this edge.
    assign pick_req = {req1 & (state_q != OWN1), req0 & (state_q != OWN0)};

    io_rr_pick u_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .valid  (pick_vld),
        .winner (pick_win)
    );

`ifdef IO_ARB_LOCK_EN
    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);

    // Counts extra beats granted by lock to the current owner; beat number is count+1.
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;

    always_comb begin
        stay       = (((state_q == OWN0) && req0 && lock0) ||
                      ((state_q == OWN1) && req1 && lock1)) && (lock_cnt_q < LOCK_LAST);
        lock_cnt_d = stay ? lock_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lock_cnt_q <= '0;
        else      lock_cnt_q <= lock_cnt_d;
    end
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1 ^ (LOCK_MAX == 0);
    assign stay        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (stay) begin
            state_d = state_q;
        end else if (pick_vld) begin
            state_d = pick_win ? OWN1 : OWN0;
            ptr_d   = ~pick_win;
        end else begin
            state_d = IDLE;
        end

        // Bus-side outputs for the beat that starts at this edge.
        own_nxt   = (state_d != IDLE);
        sel_nxt   = (state_d == OWN1);
        addr_nxt  = sel_nxt ? addr1  : addr0;
        wdata_nxt = sel_nxt ? wdata1 : wdata0;
        wr_nxt    = sel_nxt ? wren1  : wren0;
        win_nxt   = in_window(addr_nxt, ADDR_BASE, ADDR_MASK);

        gnt0_d     = (state_d == OWN0);
        gnt1_d     = (state_d == OWN1);
        abus_d     = (own_nxt && win_nxt) ? addr_nxt  : '0;
        dbus_in_d  = (own_nxt && win_nxt) ? wdata_nxt : '0;
        wren_d     = own_nxt && win_nxt && wr_nxt;
        beat_rd_d  = own_nxt && win_nxt && !wr_nxt;
        beat_err_d = own_nxt && !win_nxt;

        // Completion of the beat that ends at this edge.
        rvalid0_d = (state_q == OWN0);
        rvalid1_d = (state_q == OWN1);
        err0_d    = rvalid0_d && beat_err_q;
        err1_d    = rvalid1_d && beat_err_q;
        rdata0_d  = rvalid0_d ? (beat_rd_q ? dbus_out : '0) : rdata0_q;
        rdata1_d  = rvalid1_d ? (beat_rd_q ? dbus_out : '0) : rdata1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            abus_q     <= '0;
            dbus_in_q  <= '0;
            wren_q     <= 1'b0;
            beat_rd_q  <= 1'b0;
            beat_err_q <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            abus_q     <= abus_d;
            dbus_in_q  <= dbus_in_d;
            wren_q     <= wren_d;
            beat_rd_q  <= beat_rd_d;
            beat_err_q <= beat_err_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign abus    = abus_q;
    assign dbus_in = dbus_in_q;
    assign wren    = wren_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed and random stimulus for io_bus_arbiter, checked every cycle against a
// transaction-level model of ownership, fairness and completions.
module tb_io_bus_arbiter;

    localparam int          LOCK_MAX = 4;
    localparam logic [31:0] WIN_BASE = 32'hF000_0000;
    localparam logic [31:0] WIN_MASK = 32'hFFFF_F000;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0, req1, wren0, wren1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [31:0] dbus_out;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, wren;
    logic [31:0] rdata0, rdata1, abus, dbus_in;

    bit          m_req[2], m_wr[2], m_lock[2];
    logic [31:0] m_addr[2], m_data[2];

    assign req0   = m_req[0];
    assign req1   = m_req[1];
    assign wren0  = m_wr[0];
    assign wren1  = m_wr[1];
    assign lock0  = m_lock[0];
    assign lock1  = m_lock[1];
    assign addr0  = m_addr[0];
    assign addr1  = m_addr[1];
    assign wdata0 = m_data[0];
    assign wdata1 = m_data[1];

    always #5 clk = ~clk;

    io_bus_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wren0(wren0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0), .err0(err0),
        .req1(req1), .wren1(wren1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1), .err1(err1),
        .abus(abus), .dbus_in(dbus_in), .wren(wren), .dbus_out(dbus_out)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: who owns the bus this cycle, who is favoured next, and what each master should see.
    int          owner;
    int          favoured;
    int          streak;
    beat_t       beat;
    bit          exp_rv[2], exp_err[2];
    logic [31:0] exp_rd[2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a & WIN_MASK) == WIN_BASE;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return 32'hF000_0020;
            1:       return {20'hF0000, r[11:2], 2'b00};
            2:       return r;
            default: return {20'hF0001, r[11:0]};
        endcase
    endfunction

    task automatic model_reset();
        owner    = -1;
        favoured = 0;
        streak   = 0;
        for (int m = 0; m < 2; m++) begin
            exp_rv[m]  = 0;
            exp_err[m] = 0;
            exp_rd[m]  = '0;
        end
    endtask

    // Evaluate what happens at the coming clock edge given the inputs now applied.
    task automatic model_edge();
        int nxt;
        bit c[2];
        for (int m = 0; m < 2; m++) begin
            exp_rv[m]  = 0;
            exp_err[m] = 0;
        end
        if (owner >= 0) begin
            exp_rv[owner]  = 1;
            exp_err[owner] = !in_win(beat.addr);
            exp_rd[owner]  = (in_win(beat.addr) && !beat.wr) ? dbus_out : 32'h0;
        end
        c[0] = m_req[0] && (owner != 0);
        c[1] = m_req[1] && (owner != 1);
        nxt  = -1;
`ifdef IO_ARB_LOCK_EN
        if (owner >= 0 && m_req[owner] && m_lock[owner] && streak < LOCK_MAX) nxt = owner;
`endif
        if (nxt >= 0) begin
            streak++;
        end else begin
            if (c[0] && c[1]) nxt = favoured;
            else if (c[0])    nxt = 0;
            else if (c[1])    nxt = 1;
            if (nxt >= 0) favoured = 1 - nxt;
            streak = (nxt >= 0) ? 1 : 0;
        end
        owner = nxt;
        if (nxt >= 0) beat = '{m_wr[nxt], m_addr[nxt], m_data[nxt]};
    endtask

    task automatic check_all();
        bit iw;
        iw = (owner >= 0) && in_win(beat.addr);
        chk("gnt0",    32'(gnt0),    32'(owner == 0));
        chk("gnt1",    32'(gnt1),    32'(owner == 1));
        chk("abus",    abus,         iw ? beat.addr : 32'h0);
        chk("dbus_in", dbus_in,      iw ? beat.data : 32'h0);
        chk("wren",    32'(wren),    32'(iw && beat.wr));
        chk("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
        chk("err0",    32'(err0),    32'(exp_err[0]));
        chk("rdata0",  rdata0,       exp_rd[0]);
        chk("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
        chk("err1",    32'(err1),    32'(exp_err[1]));
        chk("rdata1",  rdata1,       exp_rd[1]);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic new_req(input int m, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input bit lk);
        m_req[m]  = 1;
        m_wr[m]   = wr;
        m_addr[m] = a;
        m_data[m] = d;
        m_lock[m] = lk;
    endtask

    task automatic drop(input int m);
        m_req[m]  = 0;
        m_lock[m] = 0;
    endtask

    // Asserts reset mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst = 1'b0;
        drop(0);
        drop(1);
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        dbus_out = '0;
        for (int m = 0; m < 2; m++) begin
            m_wr[m]   = 0;
            m_addr[m] = '0;
            m_data[m] = '0;
        end
        do_reset();

        // Write TLIM from master 0.
        new_req(0, 1, 32'hF000_0024, 32'd5, 0);
        step();
        chk("wr.gnt0", 32'(gnt0), 32'd1);
        chk("wr.abus", abus, 32'hF000_0024);
        chk("wr.dbus_in", dbus_in, 32'd5);
        chk("wr.wren", 32'(wren), 32'd1);
        drop(0);
        step();
        chk("wr.rvalid0", 32'(rvalid0), 32'd1);
        chk("wr.rdata0", rdata0, 32'd0);
        chk("wr.err0", 32'(err0), 32'd0);

        // Read TCNT from master 1.
        dbus_out = 32'h3;
        new_req(1, 0, 32'hF000_0020, 32'h0, 0);
        step();
        drop(1);
        step();
        chk("rd.rvalid1", 32'(rvalid1), 32'd1);
        chk("rd.rdata1", rdata1, 32'h3);

        // Contention with master 0 favoured, then with master 1 favoured.
        new_req(0, 0, 32'hF000_0020, 32'h0, 0);
        new_req(1, 0, 32'hF000_0024, 32'h0, 0);
        step();
        chk("rr.first0", 32'(gnt0), 32'd1);
        drop(0);
        step();
        chk("rr.then1", 32'(gnt1), 32'd1);
        drop(1);
        step();
        new_req(0, 1, 32'hF000_0120, 32'hA5, 0);
        step();
        drop(0);
        step();
        new_req(0, 0, 32'hF000_0020, 32'h0, 0);
        new_req(1, 0, 32'hF000_0024, 32'h0, 0);
        step();
        chk("rr.first1", 32'(gnt1), 32'd1);
        drop(1);
        step();
        chk("rr.then0", 32'(gnt0), 32'd1);
        drop(0);
        step();

        // Out-of-window write.
        new_req(0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 0);
        step();
        chk("oow.wren", 32'(wren), 32'd0);
        chk("oow.abus", abus, 32'd0);
        drop(0);
        step();
        chk("oow.err0", 32'(err0), 32'd1);
        chk("oow.rvalid0", 32'(rvalid0), 32'd1);
        chk("oow.rdata0", rdata0, 32'd0);

`ifdef IO_ARB_LOCK_EN
        begin
            int beats0;
            bit seen1;
            do_reset();
            beats0 = 0;
            seen1  = 0;
            new_req(0, 1, 32'hF000_0024, 32'h7, 1);
            new_req(1, 0, 32'hF000_0020, 32'h0, 0);
            for (int k = 0; k < 20 && !seen1; k++) begin
                step();
                if (gnt1) seen1 = 1;
                else if (gnt0) beats0++;
            end
            chk("lock.gnt1_seen", 32'(seen1), 32'd1);
            chk("lock.beats0", 32'(beats0), 32'(LOCK_MAX));
            drop(0);
            drop(1);
            step();
            step();
        end
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            dbus_out = $urandom;
            for (int m = 0; m < 2; m++) begin
                if (owner == m) begin
                    if ($urandom_range(0, 3) == 0)
                        new_req(m, 1'($urandom), rand_addr(), $urandom, 1'($urandom));
                    else
                        drop(m);
                end else if (m_req[m]) begin
                    if ($urandom_range(0, 15) == 0) drop(m);
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(m, 1'($urandom), rand_addr(), $urandom, 1'($urandom));
                end
            end
            step();
        end
        drop(0);
        drop(1);
        step();
        step();

        // Reset during a master-1 beat.
        new_req(1, 0, 32'hF000_0020, 32'h0, 0);
        step();
        chk("rst.own1", 32'(gnt1), 32'd1);
        do_reset();
        chk("rst.rvalid1", 32'(rvalid1), 32'd0);
        new_req(0, 0, 32'hF000_0020, 32'h0, 0);
        new_req(1, 0, 32'hF000_0024, 32'h0, 0);
        step();
        chk("rst.fav0", 32'(gnt0), 32'd1);
        drop(0);
        step();
        drop(1);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_BASE, default 32'hF0000000: base of the I/O window.
- ADDR_MASK, default 32'hFFFFF000: window decode mask.
- LOCK_MAX, default 16: maximum consecutive locked grants.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 reqN  in  1  per master N=0,1; request, held until gntN.
REQ-005 wrenN  in  1  master N write enable; addrN in 32, wdataN in 32; all held stable while reqN is high.
REQ-006 lockN  in  1  master N keep-ownership hint; honoured only under IO_ARB_LOCK_EN.
REQ-007 gntN  out  1  one-cycle pulse in the cycle master N's beat occupies the bus.
REQ-008 rdataN  out  32  registered read data.
REQ-009 rvalidN  out  1  one-cycle pulse marking rdataN valid.
REQ-010 errN  out  1  one-cycle pulse, coincident with rvalidN, for an out-of-window access.
REQ-011 Bus-side ports SHALL be:
- abus  out  32: peripheral address.
- dbus_in  out  32: peripheral write data.
- wren  out  1: peripheral write strobe.
- dbus_out  in  32: OR of the peripherals' combinational read data.

Function
REQ-012 The FSM SHALL have states IDLE, OWN0 and OWN1, with one bus beat per cycle in OWNx.
REQ-013 In IDLE, and whenever the beat is out-of-window, the arbiter SHALL drive abus=0, dbus_in=0, wren=0.
REQ-014 In OWNx, the arbiter SHALL drive abus=addrX, dbus_in=wdataX, wren=wrenX & in-window, and assert gntX.
REQ-015 An access is in-window when (addrX & ADDR_MASK) == ADDR_BASE.
REQ-016 Request-to-grant latency SHALL be 1 cycle: reqX sampled at edge E gives OWNx during cycle E..E+1.
REQ-017 For reads (wrenX=0) in-window, dbus_out SHALL be captured at the end of the OWNx cycle into rdataX, with rvalidX high for the following cycle.
REQ-018 For writes, rvalidX SHALL also pulse in that following cycle as a completion ack, with rdataX=0.
REQ-019 Out-of-window beats SHALL set rdataX=0 and assert errX together with rvalidX.
REQ-020 rdataX SHALL hold its value until the next completion for master X.
REQ-021 Round-robin arbitration: a 1-bit priority pointer SHALL favour the master that was not most recently granted.
REQ-022 On simultaneous reqs, the pointer decides the winner; with a single req, that master wins regardless of the pointer.
REQ-023 At the end of each OWNx cycle, the FSM SHALL re-arbitrate with reqX treated as consumed.
REQ-024 Back-to-back beats SHALL be allowed without passing through IDLE (OWN0->OWN1->OWN0...).
REQ-025 A master SHALL deassert reqX in the cycle after gntX, or else it is treated as a new request.
REQ-026 A reqX that drops before being granted SHALL be silently discarded.

Reset
REQ-027 On rst low, the block SHALL immediately enter IDLE, with priority pointer=0 (master 0 favoured), lock counter=0, and all gnt/rvalid/err/wren=0, abus=dbus_in=rdataN=0.
REQ-028 A beat in progress when reset asserts SHALL be dropped with no rvalid.
REQ-029 The first grant after reset release SHALL occur no earlier than 1 cycle after the first sampled req.

Configuration
REQ-030 With IO_ARB_LOCK_EN defined:
- If lockX and reqX are high at the end of OWNx, the FSM SHALL stay in OWNx and the pointer SHALL be left unchanged.
- A counter SHALL limit this to LOCK_MAX consecutive beats, after which the other master, if requesting, SHALL be granted.
- The counter SHALL clear on any ownership change or on IDLE.
REQ-031 Without IO_ARB_LOCK_EN, lockN SHALL be ignored and no lock counter SHALL be instantiated.

Structure
REQ-032 A shared package io_bus_pkg SHALL hold:
- the state enum;
- the ADDR_BASE/ADDR_MASK defaults;
- the peripheral register addresses: TCNT 32'hF0000020, TLIM 32'hF0000024, TCTL 32'hF0000120.
REQ-033 One sub-module, io_rr_pick, SHALL be used: a combinational 2-way round-robin picker taking (req, pointer) and returning (valid, winner).

Verification
REQ-034 Write: m0 writes TLIM=32'd5 to 32'hF0000024 -> gnt0 next cycle with abus=F0000024, dbus_in=5, wren=1; rvalid0 one cycle later with rdata0=0, err0=0.
REQ-035 Read: m1 reads TCNT with dbus_out=32'h3 -> rdata1=3 and rvalid1 pulse 2 cycles after req1.
REQ-036 Contention: req0 and req1 high at the same edge after reset -> gnt0, then gnt1, back-to-back; repeated with the pointer =1 -> gnt1 first.
REQ-037 Out-of-window: m0 writes 32'h00001000 -> wren stays 0, abus=0; err0 and rvalid0 pulse with rdata0=0.
REQ-038 Lock (IO_ARB_LOCK_EN, LOCK_MAX=4): m0 holds lock0/req0, m1 requests -> exactly 4 gnt0 beats, then gnt1.
REQ-039 Reset mid-beat: rst low during OWN1 -> outputs zero immediately, no rvalid1; m0-favoured arbitration after release.
